// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: load-use detection against a shifting scoreboard
// of in-flight writers, EX redirect flushing, and the HALT drain sequence.
module hazard_ctrl #(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [2:0]       id_rs,
   input  logic [2:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_reg_wr,
   input  logic [2:0]       id_write_reg,
   input  logic             id_mem_rd,
   input  logic             id_halt,
   input  logic             ex_redirect,
   output logic             stall_if,
   output logic             bubble_id,
   output logic             flush_ifid,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [1:0] S_RUN    = 2'd0;
   localparam logic [1:0] S_DRAIN  = 2'd1;
   localparam logic [1:0] S_HALTED = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [DEPTH-1:0] v_q, v_d;
   logic [DEPTH-1:0] ld_q, ld_d;
   logic [2:0]       rd_q [DEPTH];
   logic [2:0]       rd_d [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic in_run;
   logic rs_hit;
   logic rt_hit;
   logic lu;
   logic issue;

   assign in_run = (state_q == S_RUN);

   // Only the EX slot can hold a load whose data is not yet forwardable.
   assign rs_hit = id_use_rs & (id_rs == rd_q[0]);
   assign rt_hit = id_use_rt & (id_rt == rd_q[0]);
   assign lu     = id_valid & v_q[0] & ld_q[0] & (rs_hit | rt_hit);

   assign issue  = id_valid & ~lu & ~ex_redirect & in_run & ~id_halt;

   always_comb begin
      stall_if   = 1'b0;
      bubble_id  = 1'b0;
      flush_ifid = 1'b0;
      halted     = 1'b0;
      case (state_q)
         S_RUN: begin
            stall_if   = lu & ~ex_redirect;
            bubble_id  = lu | ex_redirect | id_halt;
            flush_ifid = ex_redirect;
         end
         S_DRAIN: begin
            stall_if  = 1'b1;
            bubble_id = 1'b1;
         end
         S_HALTED: begin
            stall_if  = 1'b1;
            bubble_id = 1'b1;
            halted    = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN: begin
            if (id_valid & id_halt & ~lu & ~ex_redirect) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (v_q == '0) begin
               state_d = S_HALTED;
            end
         end
         S_HALTED: ;
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      v_d[0]  = issue & id_reg_wr;
      ld_d[0] = issue & id_mem_rd;
      rd_d[0] = id_write_reg;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         v_d[i]  = v_q[i-1];
         ld_d[i] = ld_q[i-1];
         rd_d[i] = rd_q[i-1];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (in_run & stall_if & (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         v_q     <= '0;
         ld_q    <= '0;
         cnt_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            rd_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         ld_q    <= ld_d;
         cnt_q   <= cnt_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            rd_q[i] <= rd_d[i];
         end
      end
   end

   assign stall_cnt = cnt_q;

   // A redirect cannot legally arrive once the front end is frozen for HALT.
   always_ff @(posedge clk) begin
      if (!rst && !in_run) begin
         assert (!ex_redirect);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic against a
// cycle-stamped model of in-flight writers; a second instance checks counter saturation.
module tb_hazard_ctrl;

   localparam int DEPTH = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_use_rs, id_use_rt, id_reg_wr, id_mem_rd, id_halt, ex_redirect;
   logic [2:0]  id_rs, id_rt, id_write_reg;
   logic        stall_if, bubble_id, flush_ifid, halted;
   logic [15:0] stall_cnt;
   logic        s_stall_if, s_bubble_id, s_flush_ifid, s_halted;
   logic [3:0]  s_stall_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_wr(id_reg_wr),
      .id_write_reg(id_write_reg), .id_mem_rd(id_mem_rd), .id_halt(id_halt),
      .ex_redirect(ex_redirect), .stall_if(stall_if), .bubble_id(bubble_id),
      .flush_ifid(flush_ifid), .halted(halted), .stall_cnt(stall_cnt)
   );

   hazard_ctrl #(.DEPTH(DEPTH), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_wr(id_reg_wr),
      .id_write_reg(id_write_reg), .id_mem_rd(id_mem_rd), .id_halt(id_halt),
      .ex_redirect(ex_redirect), .stall_if(s_stall_if), .bubble_id(s_bubble_id),
      .flush_ifid(s_flush_ifid), .halted(s_halted), .stall_cnt(s_stall_cnt)
   );

   typedef struct {
      bit       valid;
      bit [2:0] rs;
      bit       use_rs;
      bit [2:0] rt;
      bit       use_rt;
      bit       reg_wr;
      bit [2:0] wr;
      bit       mem_rd;
      bit       halt;
      bit       redir;
   } stim_t;

   typedef struct {
      bit stall;
      bit bubble;
      bit flush;
      bit halted;
      int cnt;
   } exp_t;

   typedef struct {
      int       cyc;
      bit [2:0] rd;
      bit       ld;
   } wr_t;

   typedef enum int { M_RUN, M_DRAIN, M_HALTED } mode_t;

   exp_t  sbq[$];
   wr_t   inflight[$];
   mode_t mode;
   int    cyc;
   int    nstall;
   int    total;
   int    bad;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk("stall_if",   int'(stall_if),    int'(e.stall));
         chk("bubble_id",  int'(bubble_id),   int'(e.bubble));
         chk("flush_ifid", int'(flush_ifid),  int'(e.flush));
         chk("halted",     int'(halted),      int'(e.halted));
         chk("stall_cnt",  int'(stall_cnt),   (e.cnt > 65535) ? 65535 : e.cnt);
         chk("sat_stall_if", int'(s_stall_if), int'(e.stall));
         chk("sat_cnt",    int'(s_stall_cnt), (e.cnt > 15) ? 15 : e.cnt);
      end
   end

   function automatic stim_t mk(bit valid, bit [2:0] rs, bit use_rs, bit [2:0] rt, bit use_rt,
                                bit reg_wr, bit [2:0] wr, bit mem_rd, bit halt, bit redir);
      stim_t s;
      s.valid = valid; s.rs = rs; s.use_rs = use_rs; s.rt = rt; s.use_rt = use_rt;
      s.reg_wr = reg_wr; s.wr = wr; s.mem_rd = mem_rd; s.halt = halt; s.redir = redir;
      return s;
   endfunction

   function automatic stim_t idle();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic stim_t ld(bit [2:0] rd);
      return mk(1, 0, 0, 0, 0, 1, rd, 1, 0, 0);
   endfunction

   function automatic stim_t alu(bit [2:0] rs, bit [2:0] rt, bit [2:0] rd);
      return mk(1, rs, 1, rt, 1, 1, rd, 0, 0, 0);
   endfunction

   task automatic drive(input stim_t s);
      id_valid = s.valid; id_rs = s.rs; id_use_rs = s.use_rs; id_rt = s.rt;
      id_use_rt = s.use_rt; id_reg_wr = s.reg_wr; id_write_reg = s.wr;
      id_mem_rd = s.mem_rd; id_halt = s.halt; ex_redirect = s.redir;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(idle());
      @(posedge clk);
      #1;
      rst = 1'b0;
      inflight.delete();
      mode   = M_RUN;
      nstall = 0;
   endtask

   // Called at posedge+1: applies one decode cycle, predicts its outputs, advances the model.
   task automatic step(input stim_t s);
      exp_t e;
      bit   lu;
      bit   drained;
      drive(s);
      lu = 0;
      if (s.valid) begin
         foreach (inflight[k]) begin
            if (inflight[k].cyc == cyc - 1 && inflight[k].ld &&
                ((s.use_rs && s.rs == inflight[k].rd) || (s.use_rt && s.rt == inflight[k].rd)))
               lu = 1;
         end
      end
      e.cnt = nstall;
      if (mode == M_RUN) begin
         e.stall  = lu && !s.redir;
         e.bubble = lu || s.redir || s.halt;
         e.flush  = s.redir;
         e.halted = 0;
      end else begin
         e.stall  = 1;
         e.bubble = 1;
         e.flush  = 0;
         e.halted = (mode == M_HALTED);
      end
      sbq.push_back(e);

      if (mode == M_RUN) begin
         if (e.stall) nstall++;
         if (s.valid && !lu && !s.redir && !s.halt && s.reg_wr)
            inflight.push_back('{cyc: cyc, rd: s.wr, ld: s.mem_rd});
         if (s.valid && s.halt && !lu && !s.redir) mode = M_DRAIN;
      end else if (mode == M_DRAIN) begin
         drained = 1;
         foreach (inflight[k]) if (inflight[k].cyc >= cyc - DEPTH) drained = 0;
         if (drained) mode = M_HALTED;
      end
      cyc++;
      while (inflight.size() > 0 && inflight[0].cyc < cyc - DEPTH) void'(inflight.pop_front());
      @(posedge clk);
      #1;
   endtask

   function automatic stim_t rnd_stim();
      stim_t s;
      s.valid  = ($urandom % 4) != 0;
      s.rs     = 3'($urandom_range(0, 3));
      s.rt     = 3'($urandom_range(0, 3));
      s.use_rs = $urandom % 2;
      s.use_rt = $urandom % 2;
      s.reg_wr = ($urandom % 4) != 0;
      s.wr     = 3'($urandom_range(0, 3));
      s.mem_rd = s.reg_wr && ($urandom % 2);
      s.halt   = s.valid && ($urandom % 40) == 0;
      s.redir  = (mode == M_RUN) && ($urandom % 8) == 0;
      return s;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog expired cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int hcnt;
      total = 0; bad = 0; cyc = 0; nstall = 0; mode = M_RUN;
      do_reset();

      // load then dependent use, then the stalled ADD issues
      step(ld(3));
      step(mk(1, 3, 1, 0, 0, 1, 6, 0, 0, 0));
      step(mk(1, 3, 1, 0, 0, 1, 6, 0, 0, 0));
      chk("cnt_after_lu", int'(stall_cnt), 1);

      // independent use; use through slot 1 only; r0 is an ordinary register
      step(ld(3));
      step(alu(4, 5, 1));
      step(ld(3));
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(mk(1, 0, 0, 3, 1, 1, 2, 0, 0, 0));
      step(ld(0));
      step(alu(0, 7, 1));
      step(alu(0, 7, 1));
      chk("cnt_after_r0", int'(stall_cnt), 2);

      // redirect coinciding with load-use
      step(ld(2));
      step(mk(1, 2, 1, 0, 0, 1, 4, 0, 0, 1));
      chk("cnt_redir_lu", int'(stall_cnt), 2);

      // redirect kills HALT
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      step(idle());
      chk("halted_after_kill", int'(halted), 0);

      // halt drain with three writers in flight
      step(alu(1, 1, 1));
      step(alu(2, 2, 2));
      step(alu(3, 3, 3));
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int i = 0; i < 8; i++) step(alu(1, 2, 3));
      chk("halted_hold", int'(halted), 1);

      // reset out of HALTED, then reset in the middle of a drain
      do_reset();
      step(idle());
      step(alu(1, 1, 1));
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      step(idle());
      do_reset();
      step(idle());
      chk("cnt_after_rst", int'(stall_cnt), 0);

      hcnt = 0;
      for (int n = 0; n < 3000; n++) begin
         if (mode == M_HALTED) hcnt++;
         if (hcnt > 3 || (mode == M_DRAIN && ($urandom % 6) == 0)) begin
            hcnt = 0;
            do_reset();
         end
         step(rnd_stim());
      end

      @(negedge clk);
      #1;
      chk("queue_drained", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
